// File: rtl/iomem_pwm_led.sv
// Memory-mapped PWM LED controller on the picosoc iomem bus; one-cycle ready pulse for any access in the window.
// Duty writes land in shadow registers and move to active at period wrap, on SYNC, or continuously while disabled.
module iomem_pwm_led #(
  parameter int         NUM_CH     = 11,
  parameter int         PWM_BITS   = 8,
  parameter int         PRESCALE   = 4,
  parameter bit         ACTIVE_LOW = 1'b1,
  parameter logic [7:0] BASE_ADDR  = 8'h03
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int unsigned          CNT_MAX_I  = (32'd1 << PWM_BITS) - 32'd2;
  localparam logic [PWM_BITS-1:0]  CNT_MAX    = CNT_MAX_I[PWM_BITS-1:0];
  localparam int                   PSC_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned          PSC_LAST_I = PRESCALE - 1;
  localparam logic [PSC_W-1:0]     PSC_LAST   = PSC_LAST_I[PSC_W-1:0];

  logic                             ready_q, ready_d;
  logic [31:0]                      rdata_q, rdata_d;
  logic                             en_q, en_d;
  logic [PSC_W-1:0]                 psc_q, psc_d;
  logic [PWM_BITS-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  active_q, active_d;
  logic [NUM_CH-1:0]                level_q, level_d;

  logic        sel, wr, is_duty, ctrl_wr, sync, tick, wrap;
  logic [5:0]  idx;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign unused_ok = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, iomem_wstrb};

  always_comb begin
    sel     = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
    wr      = sel && (iomem_wstrb != 4'b0000);
    idx     = iomem_addr[7:2];
    is_duty = (idx[5:4] == 2'b01) && (int'(idx[3:0]) < NUM_CH);
    ctrl_wr = wr && (idx == 6'd0) && iomem_wstrb[0];
    sync    = ctrl_wr && iomem_wdata[1];
    en_d    = ctrl_wr ? iomem_wdata[0] : en_q;

    // Read value is taken from current state, so a write returns the old contents.
    rd_val = '0;
    case (idx)
      6'd0:    rd_val[0] = en_q;
      6'd1:    rd_val[NUM_CH-1:0] = level_q;
      6'd2:    rd_val[PWM_BITS-1:0] = CNT_MAX;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (is_duty && (idx[3:0] == i[3:0])) rd_val[PWM_BITS-1:0] = shadow_q[i];
        end
      end
    endcase

    ready_d = sel;
    rdata_d = sel ? rd_val : 32'd0;

    shadow_d = shadow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && is_duty && (idx[3:0] == i[3:0])) begin
        for (int b = 0; b < PWM_BITS; b++) begin
          if (iomem_wstrb[b/8]) shadow_d[i][b] = iomem_wdata[b];
        end
      end
    end
  end

  always_comb begin
    tick = en_q && (psc_q == PSC_LAST);
    wrap = tick && (cnt_q == CNT_MAX);
    psc_d = '0;
    cnt_d = '0;
    if (en_q) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
      if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;
      else      cnt_d = cnt_q;
    end

    // Shadow is read before any same-cycle DUTY write, so a colliding write waits a period.
    if (!en_q || sync || wrap) active_d = shadow_q;
    else                       active_d = active_q;

    level_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      level_d[i] = en_q && (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      en_q     <= 1'b0;
      psc_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      level_q  <= '0;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      level_q  <= level_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign pwm_out     = ACTIVE_LOW ? ~level_q : level_q;

endmodule

// File: tb/tb_iomem_pwm_led.sv
// Bench for iomem_pwm_led (11 channels, 8-bit duty, prescale 1, active-low pins).
// Bus reads/writes push expected rdata into a queue; a monitor pops on every ready pulse.
module tb_iomem_pwm_led;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'b0;
  logic [31:0] iomem_addr = 32'b0;
  logic [31:0] iomem_wdata = 32'b0;
  logic [31:0] iomem_rdata;
  logic [10:0] pwm_out;

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  iomem_pwm_led #(
    .NUM_CH(11), .PWM_BITS(8), .PRESCALE(1), .ACTIVE_LOW(1'b1), .BASE_ADDR(8'h03)
  ) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (iomem_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk(e.name, iomem_rdata, e.exp);
        end
      end
    end
  end

  task automatic bus(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                     input logic [31:0] exp, input string name);
    exp_t e;
    e.exp = exp;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = ws; iomem_wdata = wd;
    @(posedge clk); #1;
    chk({name, "_rdy"}, {31'b0, iomem_ready}, 32'd1);
    @(negedge clk);
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
    @(posedge clk); #1;
    chk({name, "_pulse"}, {31'b0, iomem_ready}, 32'd0);
  endtask

  task automatic foreign(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                         input string name);
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = ws; iomem_wdata = wd;
    repeat (4) begin
      @(posedge clk); #1;
      chk(name, {31'b0, iomem_ready}, 32'd0);
    end
    @(negedge clk);
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
  endtask

  // Counts active (low) samples on ch0..ch2 over n consecutive negedges.
  task automatic count(input int n, output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    repeat (n) begin
      @(negedge clk);
      if (!pwm_out[0]) c0++;
      if (!pwm_out[1]) c1++;
      if (!pwm_out[2]) c2++;
    end
  endtask

  // Returns at the first negedge where ch0 has just changed to the wanted activity.
  task automatic wait_ch0(input bit want_active, input string name);
    bit prev, cur, found;
    int n;
    prev = !pwm_out[0];
    found = 1'b0;
    n = 0;
    while (!found && n < 600) begin
      @(negedge clk);
      cur = !pwm_out[0];
      if (cur == want_active && prev != want_active) found = 1'b1;
      prev = cur;
      n++;
    end
    chk(name, {31'b0, found}, 32'd1);
  endtask

  localparam logic [31:0] A_CTRL  = 32'h0300_0000;
  localparam logic [31:0] A_LEVEL = 32'h0300_0004;
  localparam logic [31:0] A_PER   = 32'h0300_0008;
  localparam logic [31:0] A_D0    = 32'h0300_0040;
  localparam logic [31:0] A_D1    = 32'h0300_0044;
  localparam logic [31:0] A_D2    = 32'h0300_0048;
  localparam logic [31:0] A_D3    = 32'h0300_004C;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;

    #17;
    chk("rst_ready", {31'b0, iomem_ready}, 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    chk("rst_pwm", {21'b0, pwm_out}, 32'h7FF);
    @(negedge clk); resetn = 1'b1;

    bus(A_CTRL,  4'h0, 32'h0, 32'h0,  "rd_ctrl_rst");
    bus(A_LEVEL, 4'h0, 32'h0, 32'h0,  "rd_level_rst");
    bus(A_PER,   4'h0, 32'h0, 32'hFE, "rd_period");
    bus(A_D0,    4'h0, 32'h0, 32'h0,  "rd_duty0_rst");
    chk("idle_pwm", {21'b0, pwm_out}, 32'h7FF);

    bus(A_D0,   4'h1, 32'h40, 32'h0, "wr_duty0");
    bus(A_D1,   4'h1, 32'hFF, 32'h0, "wr_duty1");
    bus(A_D2,   4'h1, 32'h00, 32'h0, "wr_duty2");
    bus(A_CTRL, 4'h1, 32'h1,  32'h0, "wr_en");
    bus(A_LEVEL, 4'h0, 32'h0, 32'h003, "rd_level_start");
    count(255, c0, c1, c2);
    chk("ch0_active_64", c0, 32'd64);
    chk("ch1_always_on", c1, 32'd255);
    chk("ch2_never_on", c2, 32'd0);

    // Mid-period duty change must wait for the next boundary.
    wait_ch0(1'b0, "sync_fall_a");
    bus(A_LEVEL, 4'h0, 32'h0, 32'h002, "rd_level_mid");
    bus(A_D0, 4'h1, 32'h80, 32'h40, "wr_duty0_mid");
    count(150, c0, c1, c2);
    chk("rest_of_period_old", c0, 32'd0);
    wait_ch0(1'b1, "sync_rise_a");
    count(254, c0, c1, c2);
    chk("next_period_128", c0 + 1, 32'd128);

    // Write sampled on the wrap edge: old shadow loads, new one a period later.
    wait_ch0(1'b1, "sync_rise_b");
    repeat (252) @(negedge clk);
    bus(A_D0, 4'h1, 32'h20, 32'h80, "wr_duty0_wrap");
    count(255, c0, c1, c2);
    chk("wrap_period_old", c0, 32'd128);
    count(255, c0, c1, c2);
    chk("wrap_period_new", c0, 32'd32);

    // SYNC applies shadows immediately.
    wait_ch0(1'b0, "sync_fall_b");
    bus(A_D0,   4'h1, 32'h80, 32'h20, "wr_duty0_sync");
    bus(A_CTRL, 4'h1, 32'h3,  32'h1,  "wr_ctrl_sync");
    count(20, c0, c1, c2);
    chk("sync_immediate", c0, 32'd20);
    bus(A_CTRL, 4'h0, 32'h0, 32'h1, "rd_ctrl_sync");
    bus(A_D0, 4'h2, 32'h0000_AB00, 32'h80, "wr_duty0_hi");
    bus(A_D0, 4'h0, 32'h0, 32'h80, "rd_duty0_hi");
    bus(A_D3, 4'h3, 32'h1234_0155, 32'h0, "wr_duty3");
    bus(A_D3, 4'h0, 32'h0, 32'h55, "rd_duty3");

    // Unmapped offsets complete with zero data and no side effects.
    bus(32'h0300_0010, 4'h0, 32'h0,        32'h0, "rd_unmapped_10");
    bus(32'h0300_0010, 4'hF, 32'hFFFF_FFFF, 32'h0, "wr_unmapped_10");
    bus(32'h0300_0070, 4'hF, 32'hFF,       32'h0, "wr_unmapped_70");
    bus(32'h0300_0070, 4'h0, 32'h0,        32'h0, "rd_unmapped_70");
    bus(A_PER, 4'hF, 32'h0, 32'hFE, "wr_period");
    bus(A_PER, 4'h0, 32'h0, 32'hFE, "rd_period_after");
    foreign(32'h0200_0000, 4'h0, 32'h0, "foreign_rd_noready");
    foreign(32'h0200_0000, 4'h1, 32'h0, "foreign_wr_noready");
    bus(A_CTRL, 4'h0, 32'h0, 32'h1,  "rd_ctrl_unchanged");
    bus(A_D0,   4'h0, 32'h0, 32'h80, "rd_duty0_unchanged");

    // Reset during an active period with an access outstanding.
    @(negedge clk);
    chk("pre_rst_ch1_on", {31'b0, pwm_out[1]}, 32'd0);
    iomem_valid = 1'b1; iomem_addr = A_CTRL; iomem_wstrb = 4'h0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_pwm", {21'b0, pwm_out}, 32'h7FF);
    @(posedge clk); #1;
    chk("arst_noready", {31'b0, iomem_ready}, 32'd0);
    @(negedge clk);
    iomem_valid = 1'b0;
    #2 resetn = 1'b1;
    bus(A_CTRL,  4'h0, 32'h0, 32'h0, "rd_ctrl_post_rst");
    bus(A_D0,    4'h0, 32'h0, 32'h0, "rd_duty0_post_rst");
    bus(A_D3,    4'h0, 32'h0, 32'h0, "rd_duty3_post_rst");
    bus(A_LEVEL, 4'h0, 32'h0, 32'h0, "rd_level_post_rst");
    chk("post_rst_pwm", {21'b0, pwm_out}, 32'h7FF);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
